// File: rtl/psum_accumulator.sv
// psum_accumulator: sums kernelCount signed partial sums on top of a per-output
// bias, requantises (arithmetic shift right + saturation to dataWidth) and hands
// the result downstream over a valid/ready handshake.
// Optional feature macro: PSUM_RELU_EN (clamp negative results to zero).
module psum_accumulator #(
  parameter int dataWidth   = 16,
  parameter int accWidth    = 32,
  parameter int kernelCount = 9,
  parameter int shiftAmt    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dataWidth-1:0] psum,
  input  logic [dataWidth-1:0] bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [dataWidth-1:0] out_data,
  output logic                 busy
);

  localparam int CntW = $clog2(kernelCount + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(kernelCount - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [accWidth-1:0] SatMax =
    {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [accWidth-1:0] SatMin =
    {{(accWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [accWidth-1:0]   acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [dataWidth-1:0]  out_data_q, out_data_d;

  logic [accWidth-1:0]   psum_ext_s;
  logic [accWidth-1:0]   bias_ext_s;
  logic [accWidth-1:0]   sum_first_s;
  logic [accWidth-1:0]   sum_next_s;

  // Sign-extend a dataWidth value to accumulator width.
  function automatic logic [accWidth-1:0] sext(input logic [dataWidth-1:0] v);
    sext = {{(accWidth-dataWidth){v[dataWidth-1]}}, v};
  endfunction

  // Shift, saturate to dataWidth and optionally clamp negatives to zero.
  function automatic logic [dataWidth-1:0] requant(input logic [accWidth-1:0] a);
    logic signed [accWidth-1:0] r;
    logic [dataWidth-1:0]       sat;
    r = $signed(a) >>> shiftAmt;
    if (r > SatMax) begin
      sat = SatMax[dataWidth-1:0];
    end else if (r < SatMin) begin
      sat = SatMin[dataWidth-1:0];
    end else begin
      sat = r[dataWidth-1:0];
    end
`ifdef PSUM_RELU_EN
    if (sat[dataWidth-1]) begin
      requant = {dataWidth{1'b0}};
    end else begin
      requant = sat;
    end
`else
    requant = sat;
`endif
  endfunction

  assign psum_ext_s  = sext(psum);
  assign bias_ext_s  = sext(bias);
  assign sum_first_s = bias_ext_s + psum_ext_s;
  assign sum_next_s  = acc_q + psum_ext_s;

  // Handshake outputs are pure state decodes; no path from out_ready to in_ready.
  assign in_ready  = (state_q != ST_OUT);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

  // Next-state, accumulator and result computation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d = sum_first_s;
          cnt_d = CntW'(1);
          if (kernelCount == 1) begin
            out_data_d = requant(sum_first_s);
            state_d    = ST_OUT;
          end else begin
            state_d    = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = sum_next_s;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            out_data_d = requant(sum_next_s);
            state_d    = ST_OUT;
          end else begin
            state_d    = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= {accWidth{1'b0}};
      cnt_q      <= {CntW{1'b0}};
      out_data_q <= {dataWidth{1'b0}};
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator. Three instances cover
// (kernelCount=9, shiftAmt=0), (9, 8) and (1, 0). Expected results are pushed
// to per-instance queues when a group is driven and popped at handshake time.
module tb_psum_accumulator;

  typedef logic [15:0] vec9_t [9];

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [15:0] psum;
  logic [15:0] bias;
  logic [2:0]  out_valid;
  logic        out_ready;
  logic [15:0] out_data [3];
  logic [2:0]  busy;

  int checks;
  int errors;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  psum_accumulator #(.dataWidth(16), .accWidth(32), .kernelCount(9), .shiftAmt(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .psum(psum), .bias(bias), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .busy(busy[0]));

  psum_accumulator #(.dataWidth(16), .accWidth(32), .kernelCount(9), .shiftAmt(8)) u_dut_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .psum(psum), .bias(bias), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .busy(busy[1]));

  psum_accumulator #(.dataWidth(16), .accWidth(32), .kernelCount(1), .shiftAmt(0)) u_dut_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .psum(psum), .bias(bias), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_data(out_data[2]), .busy(busy[2]));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bias + sum of psums, arithmetic shift, saturate, optional ReLU.
  function automatic logic [15:0] model(input logic [15:0] b, input vec9_t ps,
                                         input int n, input int sh);
    longint a;
    longint r;
    a = longint'($signed(b));
    for (int i = 0; i < n; i++) a = a + longint'($signed(ps[i]));
    r = a >>> sh;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef PSUM_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  function automatic vec9_t fill(input logic [15:0] v);
    vec9_t p;
    for (int i = 0; i < 9; i++) p[i] = v;
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [15:0] e);
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Pop expected value for an instance and compare with what it presents.
  task automatic pop_cmp(input int sel);
    logic [15:0] e;
    int depth;
    case (sel)
      0: depth = q0.size();
      1: depth = q1.size();
      default: depth = q2.size();
    endcase
    check_val($sformatf("q_nonempty%0d", sel), 32'(depth != 0), 32'd1);
    if (depth != 0) begin
      case (sel)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check_val($sformatf("out_data%0d", sel), 32'(out_data[sel]), 32'(e));
    end
  endtask

  // Scoreboard side: compare whenever a result is handed off.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && out_ready) pop_cmp(i);
      end
    end
  end

  // Drive one full group into instance sel; called at posedge+1.
  task automatic send_group(input int sel, input logic [15:0] b, input vec9_t ps,
                            input bit gaps, output logic [15:0] e);
    int n;
    int sh;
    int k;
    int guard;
    bit gap;
    bit acc;
    n = (sel == 2) ? 1 : 9;
    sh = (sel == 1) ? 8 : 0;
    e = model(b, ps, n, sh);
    push_exp(sel, e);
    k = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      guard++;
      gap = gaps && ($urandom_range(0, 2) == 0);
      if (gap) begin
        in_valid = 3'b000;
        acc = 1'b0;
      end else begin
        in_valid = 3'(1 << sel);
        psum = ps[k];
        bias = b;
        acc = in_ready[sel];
      end
      tick();
      if (acc) k++;
    end
    in_valid = 3'b000;
    check_val("group_done", 32'(k), 32'(n));
    check_val("latency_valid", 32'(out_valid[sel]), 32'd1);
  endtask

  initial begin
    vec9_t p;
    logic [15:0] e;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 3'b000;
    psum = 16'h0000;
    bias = 16'h0000;
    out_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("rst_in_ready", 32'(in_ready[i]), 32'd1);
      check_val("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check_val("rst_out_data", 32'(out_data[i]), 32'd0);
      check_val("rst_busy", 32'(busy[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Basic accumulation: 5 + (1..9) = 50.
    for (int i = 0; i < 9; i++) p[i] = 16'(i + 1);
    send_group(0, 16'd5, p, 1'b0, e);
    check_val("basic_exp", 32'(e), 32'h0032);
    tick();
    check_val("basic_idle", 32'(busy[0]), 32'd0);

    // Saturation both directions.
    send_group(0, 16'd0, fill(16'h7FFF), 1'b0, e);
    tick();
    send_group(0, 16'd0, fill(16'h8000), 1'b0, e);
    tick();

    // Shift of 8, positive and negative totals.
    send_group(1, 16'd0, fill(16'h0100), 1'b0, e);
    tick();
    send_group(1, 16'hF600, fill(16'h0100), 1'b0, e);
    tick();

    // Backpressure: hold out_ready low 5 cycles while pushing ignored beats.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) p[i] = 16'(i + 1);
    send_group(0, 16'd5, p, 1'b0, e);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", 32'(out_valid[0]), 32'd1);
      check_val("bp_data", 32'(out_data[0]), 32'(e));
      check_val("bp_in_ready", 32'(in_ready[0]), 32'd0);
      in_valid = 3'b001;
      psum = 16'h1234;
      bias = 16'h0777;
      tick();
    end
    in_valid = 3'b000;
    out_ready = 1'b1;
    tick();
    check_val("bp_release_idle", 32'(busy[0]), 32'd0);
    check_val("bp_release_valid", 32'(out_valid[0]), 32'd0);

    // Gaps inside groups give the same results as gap-free.
    send_group(0, 16'd5, p, 1'b1, e);
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 9; i++) p[i] = 16'($urandom_range(0, 16'hFFFF));
      send_group(r[0] ? 1 : 0, 16'($urandom_range(0, 16'hFFFF)), p, 1'b1, e);
      tick();
    end

    // Reset in the middle of a group discards it.
    for (int i = 0; i < 4; i++) begin
      in_valid = 3'b001;
      psum = 16'd100;
      bias = 16'd100;
      tick();
    end
    in_valid = 3'b000;
    rst = 1'b1;
    tick();
    check_val("midrst_valid", 32'(out_valid[0]), 32'd0);
    check_val("midrst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    send_group(0, 16'd0, fill(16'd2), 1'b0, e);
    check_val("midrst_exp", 32'(e), 32'd18);
    tick();

    // Single-term groups go straight to OUT.
    p = fill(16'd4);
    send_group(2, 16'd3, p, 1'b0, e);
    tick();
    check_val("k1_idle", 32'(busy[2]), 32'd0);
    send_group(2, 16'hFFF0, fill(16'h0005), 1'b0, e);
    tick();

    tick();
    check_val("q0_drained", 32'(q0.size()), 32'd0);
    check_val("q1_drained", 32'(q1.size()), 32'd0);
    check_val("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Output stage directly downstream of the MAC array in the CNN accelerator. It takes the stream of signed partial sums produced by the MAC units for one output pixel and adds them, starting from a per-output bias. It then requantises the total with an arithmetic right shift, saturates it to `dataWidth`, and optionally applies ReLU. Finished results leave on a valid/ready handshake toward the output feature-map writer.

## Interface
- `dataWidth`, 16: width of partial sums, bias and result; all are signed two's complement.
- `accWidth`, 32: internal accumulator width; must be ≥ `dataWidth` + clog2(`kernelCount`+1).
- `kernelCount`, 9: number of partial sums per output; legal range ≥ 1.
- `shiftAmt`, 8: arithmetic right shift applied to the accumulator before saturation.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset rst, synchronous, active-high; clock clk.
- `in_valid` input 1: `psum` is valid.
- `in_ready` output 1: block accepts `psum` this cycle.
- `psum` input `dataWidth`: signed partial sum from the MAC stage.
- `bias` input `dataWidth`: signed bias, sampled only on the first beat of a group.
- `out_valid` output 1: `out_data` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output `dataWidth`: requantised, saturated result.
- `busy` output 1: high in ACCUM or OUT.

## Operation
- A beat is accepted when `in_valid` && `in_ready` at a rising edge.
- **FSM states:** IDLE, ACCUM, OUT.
- **IDLE**
  - `in_ready`=1.
  - On the first beat, `acc` ← sext(`bias`) + sext(`psum`) and `cnt` ← 1.
  - Next state is OUT if `kernelCount`==1, else ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - Each beat: `acc` ← `acc` + sext(`psum`), `cnt` ← `cnt`+1.
  - On the beat where `cnt`==`kernelCount`-1, the final value is requantised into `out_data` and the state moves to OUT.
  - Cycles without `in_valid` leave `acc` and `cnt` unchanged; gaps are allowed.
- **OUT**
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` stays stable until `out_ready`=1; then next state is IDLE.
  - `in_valid` is ignored while in OUT.
- **Requantise**
  - r = (final `acc`) >>> `shiftAmt`.
  - If r > 2^(`dataWidth`-1)-1, output the maximum positive value. If r < -2^(`dataWidth`-1), output the minimum negative value. Otherwise output r[`dataWidth`-1:0].
- **Accumulator:** wraps modulo 2^`accWidth`; no overflow flag. Sizing is the integrator's responsibility.
- **`out_ready` with `out_valid`=0:** no effect.

## Timing
- **Reset values:** state=IDLE, `acc`=0, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
- **Reset mid-group or while in OUT:** the pending result is discarded. The next group starts clean from IDLE in the cycle after `rst` deasserts.
- **Latency:** `out_valid` rises in the cycle after the edge that accepts the last beat. Requantisation is registered on that same edge.
- **Throughput:** at most one result per `kernelCount`+1 cycles. There is no overlap between OUT and the next group.
- **Timing path:** `in_ready` is a function of state only, with no combinational path from `out_ready`.

## Configuration
- **`PSUM_RELU_EN` defined:** after saturation, a negative result is replaced by 0 before it is registered into `out_data`.
- **`PSUM_RELU_EN` undefined:** the signed saturated value passes through unchanged.

## Test plan
1. **Basic accumulation** (`shiftAmt`=0, `kernelCount`=9): `bias`=5, psums 1..9 back-to-back, `out_ready`=1 → `out_valid` one cycle after the 9th beat, `out_data`=50 (0x0032), then IDLE.
2. **Saturation** (`shiftAmt`=0, `bias`=0):
   - Nine beats of 0x7FFF → `out_data`=0x7FFF.
   - Nine beats of 0x8000 → 0x8000 without ReLU, 0x0000 with `PSUM_RELU_EN`.
3. **Shift and ReLU** (`shiftAmt`=8):
   - `bias`=0, nine beats of 0x0100 → `out_data`=9.
   - `bias`=-2560, same psums → -1 (0xFFFF) without ReLU, 0 with `PSUM_RELU_EN`.
4. **Backpressure and gaps:**
   - Hold `out_ready`=0 for 5 cycles after `out_valid` rises → `out_valid` stays 1, `out_data` stays stable, `in_ready`=0, and concurrent `in_valid` beats are not consumed. Release → IDLE next cycle.
   - Insert random `in_valid` gaps inside a group → same result as gap-free.
5. **Reset mid-group:** assert `rst` after 4 beats → `out_valid`=0, `busy`=0. Then a full group with `bias`=0 and psums all 2 → `out_data`=18 (`shiftAmt`=0).
6. **Single-term group** (`kernelCount`=1, `shiftAmt`=0): `bias`=3, `psum`=4 → `out_valid` next cycle with `out_data`=7; no ACCUM state is visited.
